fpu_op_scheduler: RTL and testbench
===================================

// Module: fpu_op_scheduler
// PURPOSE
//  Round-robin scheduler sharing one multi-cycle FP execution unit among NUM_REQ requesters.
//  Grants one requester at a time, issues a start pulse with the opcode, and times the operation
//  with an internal latency counter loaded from a per-opcode latency table. On completion it
//  returns a one-hot done pulse. Sits between the co-processor issue logic and the FP datapath.
// PARAMETERS
//  NUM_REQ   4   number of requesters (>=2)
//  OP_BITS   2   opcode width; latency table has 2**OP_BITS entries
//  LAT_BITS  4   width of each latency entry and of the internal cycle counter
//  CNT_BITS  16  width of completed-operation counter
// PORTS
//  clk        in   1                      clock, all state on rising edge
//  n_rst      in   1                      asynchronous, active-low reset
//  req        in   NUM_REQ                request per requester, level, held until grant
//  req_op     in   NUM_REQ*OP_BITS        opcode per requester; slice i = [i*OP_BITS +: OP_BITS]
//  lat_cfg    in   (2**OP_BITS)*LAT_BITS  latency in cycles per opcode; entry k = [k*LAT_BITS +: LAT_BITS]
//  abort      in   1                      synchronous abort of the operation in flight
//  grant      out  NUM_REQ                one-hot, held from issue through the DONE cycle
//  ex_start   out  1                      one-cycle start pulse to execution unit
//  ex_op      out  OP_BITS                opcode of the granted request, stable while grant != 0
//  done       out  NUM_REQ                one-hot one-cycle completion pulse (equals grant)
//  aborted    out  1                      one-cycle pulse when an in-flight op is aborted
//  busy       out  1                      1 whenever state != IDLE
//  op_count   out  CNT_BITS               completed operations, wraps at 2**CNT_BITS
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, ex_start=0, ex_op=0, done=0, aborted=0, busy=0, op_count=0, rr_ptr=0, cnt=0.
//  All outputs registered. States: IDLE, EXEC, DONE.
//  IDLE: if req!=0, winner = first set req scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//   At that edge: grant<=onehot(winner), ex_op<=req_op[winner], ex_start<=1, cnt<=1,
//   L<=max(lat_cfg[req_op[winner]],1) (latency 0 treated as 1), rr_ptr<=(winner+1)%NUM_REQ, ->EXEC.
//   If req==0, stay IDLE, outputs idle.
//  EXEC: ex_start high only in the first EXEC cycle. Each cycle: if cnt==L -> DONE with done<=grant;
//   else cnt<=cnt+1. EXEC therefore lasts exactly L cycles. lat_cfg changes after issue are ignored.
//  DONE: one cycle, done==grant, op_count+1 (wraps). Next edge: grant<=0, ->IDLE.
//   Arbitration resumes in the following IDLE cycle, so back-to-back ops are separated by 1 idle cycle.
//  Requests: req/req_op sampled only in IDLE. Dropping req while granted has no effect; the op completes.
//   Requester must drop req on seeing done, else it is re-arbitrated (at lowest priority due to rr_ptr).
//  abort: in EXEC or DONE -> next edge grant<=0, done<=0, ex_start<=0, aborted<=1 for one cycle,
//   ->IDLE, op_count unchanged, rr_ptr keeps its post-issue value. abort in IDLE ignored (no pulse).
//   abort in the DONE cycle suppresses nothing already visible: done pulse in that cycle stands and counts.
//  ex_start and done never coincide (L>=1). grant is one-hot or zero at all times.
//  n_rst mid-operation: all state returns to reset values asynchronously; no done/aborted pulse issued.
// TESTING
//  1 req=4'b0001, op=0, lat[0]=3 -> grant=0001 + ex_start next edge; done=0001 exactly 3 cycles after ex_start; op_count=1.
//  2 req=4'b1111 held, all lat=1 -> grants in order 0001,0010,0100,1000,0001; 1 idle cycle between ops.
//  3 lat[2]=0, op 2 -> treated as 1: done 1 cycle after ex_start.
//  4 abort 2 cycles into lat=5 op -> aborted pulse, grant=0, no done, op_count unchanged, next grant to rr_ptr order.
//  5 change lat_cfg and drop req mid-EXEC -> completion time and ex_op unchanged.
//  6 n_rst low during EXEC -> all outputs 0 immediately; after release req=0010 granted first round from ptr 0.

Source files
------------

// File: rtl/fpu_op_scheduler.sv
// Round-robin arbiter sharing one multi-cycle FP execution unit.
// Times each op with a latency counter loaded from a per-opcode table.
module fpu_op_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int OP_BITS  = 2,
    parameter int LAT_BITS = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*OP_BITS-1:0]      req_op,
    input  logic [(2**OP_BITS)*LAT_BITS-1:0] lat_cfg,
    input  logic                            abort,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            ex_start,
    output logic [OP_BITS-1:0]              ex_op,
    output logic [NUM_REQ-1:0]              done,
    output logic                            aborted,
    output logic                            busy,
    output logic [CNT_BITS-1:0]             op_count
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t              r_state, w_state;
    logic [NUM_REQ-1:0]  r_grant, w_grant;
    logic                r_ex_start, w_ex_start;
    logic [OP_BITS-1:0]  r_ex_op, w_ex_op;
    logic [NUM_REQ-1:0]  r_done, w_done;
    logic                r_aborted, w_aborted;
    logic [CNT_BITS-1:0] r_count, w_count;
    logic [PW-1:0]       r_ptr, w_ptr;
    logic [LAT_BITS-1:0] r_cnt, w_cnt;
    logic [LAT_BITS-1:0] r_lat, w_lat;

    logic                w_found;
    logic [PW-1:0]       w_win;
    logic [OP_BITS-1:0]  w_op;
    logic [LAT_BITS-1:0] w_lat_raw;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // First set request at or after the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[rr_idx(r_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, i);
            end
        end
    end

    assign w_op      = req_op[w_win*OP_BITS +: OP_BITS];
    assign w_lat_raw = lat_cfg[w_op*LAT_BITS +: LAT_BITS];

    always_comb begin
        w_state    = r_state;
        w_grant    = r_grant;
        w_ex_start = 1'b0;
        w_ex_op    = r_ex_op;
        w_done     = '0;
        w_aborted  = 1'b0;
        w_count    = r_count;
        w_ptr      = r_ptr;
        w_cnt      = r_cnt;
        w_lat      = r_lat;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state    = S_EXEC;
                    w_grant    = NUM_REQ'(1) << w_win;
                    w_ex_op    = w_op;
                    w_ex_start = 1'b1;
                    w_cnt      = LAT_BITS'(1);
                    // A zero-latency entry still needs one EXEC cycle
                    w_lat      = (w_lat_raw == '0) ? LAT_BITS'(1) : w_lat_raw;
                    w_ptr      = rr_idx(w_win, 1);
                end
            end
            S_EXEC: begin
                if (abort) begin
                    w_state   = S_IDLE;
                    w_grant   = '0;
                    w_ex_op   = '0;
                    w_cnt     = '0;
                    w_aborted = 1'b1;
                end else if (r_cnt == r_lat) begin
                    w_state = S_DONE;
                    w_done  = r_grant;
                    w_count = r_count + CNT_BITS'(1);
                end else begin
                    w_cnt = r_cnt + LAT_BITS'(1);
                end
            end
            S_DONE: begin
                w_state   = S_IDLE;
                w_grant   = '0;
                w_ex_op   = '0;
                w_cnt     = '0;
                w_aborted = abort;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_ex_start <= 1'b0;
            r_ex_op    <= '0;
            r_done     <= '0;
            r_aborted  <= 1'b0;
            r_count    <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_lat      <= '0;
        end else begin
            r_state    <= w_state;
            r_grant    <= w_grant;
            r_ex_start <= w_ex_start;
            r_ex_op    <= w_ex_op;
            r_done     <= w_done;
            r_aborted  <= w_aborted;
            r_count    <= w_count;
            r_ptr      <= w_ptr;
            r_cnt      <= w_cnt;
            r_lat      <= w_lat;
        end
    end

    assign grant    = r_grant;
    assign ex_start = r_ex_start;
    assign ex_op    = r_ex_op;
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign busy     = (r_state != S_IDLE);
    assign op_count = r_count;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler: vector table plus
// hand-written sequences for abort, reset and round-robin order.
module tb_fpu_op_scheduler;

    logic        clk;
    logic        n_rst;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [15:0] lat_cfg;
    logic        abort;
    logic [3:0]  grant;
    logic        ex_start;
    logic [1:0]  ex_op;
    logic [3:0]  done;
    logic        aborted;
    logic        busy;
    logic [15:0] op_count;

    int checks;
    int errors;
    int exp_cnt;

    fpu_op_scheduler #(
        .NUM_REQ(4), .OP_BITS(2), .LAT_BITS(4), .CNT_BITS(16)
    ) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_op(req_op),
        .lat_cfg(lat_cfg), .abort(abort), .grant(grant),
        .ex_start(ex_start), .ex_op(ex_op), .done(done),
        .aborted(aborted), .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic [7:0]  op;
        logic [15:0] lat;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_op;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        req   = '0;
        abort = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        exp_cnt = 0;
    endtask

    // Issue from IDLE, measure EXEC length, check DONE and return to IDLE
    task automatic run_op(input string name, input logic [3:0] r, input logic [7:0] op,
                          input logic [15:0] lat, input logic [3:0] eg,
                          input logic [1:0] eo, input int el);
        int n;
        req = r; req_op = op; lat_cfg = lat;
        tick();
        chk({name, " grant"}, 32'(grant), 32'(eg));
        chk({name, " ex_op"}, 32'(ex_op), 32'(eo));
        chk({name, " ex_start"}, 32'(ex_start), 32'd1);
        req = '0;
        n = 0;
        while (n < 40 && done == '0) begin
            tick();
            n++;
        end
        exp_cnt++;
        chk({name, " latency"}, 32'(n), 32'(el));
        chk({name, " done"}, 32'(done), 32'(eg));
        chk({name, " op_count"}, 32'(op_count), 32'(exp_cnt));
        tick();
        chk({name, " idle"}, {28'd0, grant}, 32'd0);
        chk({name, " busy"}, 32'(busy), 32'd0);
    endtask

    logic [3:0] rr_exp[5];
    int n;

    initial begin
        checks = 0; errors = 0; exp_cnt = 0;
        n_rst = 1'b0; req = '0; req_op = '0; lat_cfg = '0; abort = 1'b0;

        vecs[0] = '{"v0_lat3",   4'b0001, 8'h00, 16'h0003, 4'b0001, 2'd0, 3};
        vecs[1] = '{"v1_lat2",   4'b0001, 8'h01, 16'h0020, 4'b0001, 2'd1, 2};
        vecs[2] = '{"v2_rr3",    4'b1001, 8'hC0, 16'h5000, 4'b1000, 2'd3, 5};
        vecs[3] = '{"v3_rr0",    4'b1001, 8'hC1, 16'h0040, 4'b0001, 2'd1, 4};
        vecs[4] = '{"v4_lat0",   4'b0100, 8'h20, 16'h7077, 4'b0100, 2'd2, 1};
        vecs[5] = '{"v5_lat15",  4'b0110, 8'h0C, 16'hF000, 4'b0010, 2'd3, 15};

        #12;
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst op_count", 32'(op_count), 32'd0);
        chk("rst ex_op", 32'(ex_op), 32'd0);
        n_rst = 1'b1;
        tick();
        chk("idle no req", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].name, vecs[i].req, vecs[i].op, vecs[i].lat,
                   vecs[i].exp_grant, vecs[i].exp_op, vecs[i].exp_lat);

        // lat_cfg change and req drop mid-EXEC are ignored (ptr=2)
        req = 4'b0010; req_op = 8'h0C; lat_cfg = 16'h4000;
        tick();
        chk("chg grant", 32'(grant), 32'b0010);
        lat_cfg = 16'h1111; req = '0; req_op = '0;
        n = 0;
        while (n < 40 && done == '0) begin
            tick();
            n++;
            if (done == '0) chk("chg ex_op", 32'(ex_op), 32'd3);
        end
        exp_cnt++;
        chk("chg latency", 32'(n), 32'd4);
        chk("chg done ex_op", 32'(ex_op), 32'd3);
        chk("chg op_count", 32'(op_count), 32'(exp_cnt));
        tick();

        // abort two cycles into a latency-5 op (ptr=2)
        req = 4'b0100; req_op = 8'h10; lat_cfg = 16'h0050;
        tick();
        chk("abt grant", 32'(grant), 32'b0100);
        req = '0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt aborted", 32'(aborted), 32'd1);
        chk("abt grant0", 32'(grant), 32'd0);
        chk("abt done0", 32'(done), 32'd0);
        chk("abt busy", 32'(busy), 32'd0);
        chk("abt op_count", 32'(op_count), 32'(exp_cnt));
        tick();
        chk("abt pulse end", 32'(aborted), 32'd0);
        chk("abt no late done", 32'(done), 32'd0);
        run_op("post_abt", 4'b0101, 8'h00, 16'h0002, 4'b0001, 2'd0, 2);

        // abort during DONE: done stands and counts (ptr=1)
        req = 4'b0010; req_op = 8'h00; lat_cfg = 16'h0000;
        tick();
        req = '0;
        tick();
        exp_cnt++;
        chk("dabt done", 32'(done), 32'b0010);
        chk("dabt count", 32'(op_count), 32'(exp_cnt));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("dabt aborted", 32'(aborted), 32'd1);
        chk("dabt grant0", 32'(grant), 32'd0);
        chk("dabt count kept", 32'(op_count), 32'(exp_cnt));
        tick();

        // idle abort is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle abort", 32'(aborted), 32'd0);

        // async reset mid-EXEC (ptr=2, winner 2 moves ptr to 3)
        req = 4'b0100; req_op = 8'h00; lat_cfg = 16'h0005;
        tick();
        chk("rmid grant", 32'(grant), 32'b0100);
        req = '0;
        tick();
        #2;
        n_rst = 1'b0;
        #1;
        chk("rmid grant0", 32'(grant), 32'd0);
        chk("rmid busy0", 32'(busy), 32'd0);
        chk("rmid count0", 32'(op_count), 32'd0);
        chk("rmid misc0", {28'd0, done, ex_start, aborted, ex_op}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        exp_cnt = 0;
        run_op("post_rst", 4'b1010, 8'h00, 16'h0001, 4'b0010, 2'd0, 1);

        // round-robin with all requests held and latency 1
        do_reset();
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        req = 4'b1111; req_op = 8'h00; lat_cfg = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr%0d grant", i), 32'(grant), 32'(rr_exp[i]));
            chk($sformatf("rr%0d start", i), 32'(ex_start), 32'd1);
            if (i == 4) req = '0;
            tick();
            chk($sformatf("rr%0d done", i), 32'(done), 32'(rr_exp[i]));
            tick();
            chk($sformatf("rr%0d gap", i), 32'(busy), 32'd0);
        end
        chk("rr op_count", 32'(op_count), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
